dma_line_unpacker: RTL and testbench
====================================

Name: dma_line_unpacker

Overview:
- Read-side counterpart to the AFU result packer.
- Pops 512-bit cache lines from the DMA read channel and emits them as a stream of 32-bit words under a valid/ready handshake, for a consumer such as a key/input loader.
- Counts lines against a software-programmed size and flags completion, mirroring the write path's done semantics.

Parameters:
- CL_DATA_WIDTH, 512, cache-line width in bits.
- WORD_WIDTH, 32, output word width; CL_DATA_WIDTH must be a multiple of it.
- SIZE_WIDTH, 65, width of the line-count input (matches the memory-map size width).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- go  input  1  single-cycle start pulse from MMIO.
- num_lines  input  SIZE_WIDTH  cache lines to consume; sampled on accepted go.
- dma_empty  input  1  DMA read FIFO empty.
- dma_rd_data  input  CL_DATA_WIDTH  head line; valid whenever !dma_empty (show-ahead).
- dma_rd_en  output  1  pops the head line in the same cycle.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WORD_WIDTH  current word.
- out_last  output  1  final word of the final line.
- done  output  1  all lines emitted; held until next accepted go.

Behaviour:
- Reset values: dma_rd_en=0, out_valid=0, out_data=0, out_last=0, done=0. State goes to IDLE and all counters clear.
- WPL = CL_DATA_WIDTH/WORD_WIDTH (16).
- Word order: word k = line bits [k*WORD_WIDTH +: WORD_WIDTH]; word 0 goes out first.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE/DONE, go=1:
  - Latch num_lines into lines_rem and clear done.
  - If num_lines==0, go to DONE; done=1 the next cycle.
  - Otherwise go to FETCH.
- go in FETCH/DRAIN is ignored.
- FETCH:
  - dma_rd_en = !dma_empty.
  - On a pop, load dma_rd_data into line_r, set word_idx=0, decrement lines_rem, and go to DRAIN.
  - out_valid=0 throughout FETCH.
- DRAIN:
  - out_valid=1 and out_data = line_r[WORD_WIDTH-1:0].
  - On a beat (out_valid && out_ready): shift line_r right by WORD_WIDTH and increment word_idx.
  - out_valid, out_data and out_last must stay stable while out_ready=0.
- Last word of a line (word_idx==WPL-1) beat:
  - lines_rem!=0 and !dma_empty: dma_rd_en=1 in the same cycle, line_r reloads, and the state stays DRAIN. This gives zero bubble.
  - lines_rem!=0 and dma_empty: go to FETCH.
  - lines_rem==0: go to DONE.
- dma_rd_en is asserted only in FETCH or on a last-word beat. It is never asserted while dma_empty=1.
- out_last=1 only while word_idx==WPL-1, lines_rem==0 and in DRAIN.
- DONE: done=1 and out_valid=0.
- Latency: first word appears the cycle after the FETCH pop. Throughput is 1 word/cycle with out_ready high and the FIFO non-empty.
- Reset mid-operation: asynchronous return to IDLE. No further pops or beats occur, and the partial line is discarded.
- Counters:
  - lines_rem is SIZE_WIDTH bits and decrements on each pop. It never wraps, because pops stop at 0.
  - word_idx is $clog2(WPL) bits and wraps to 0 after the last-word beat.

Decomposition:
- Shared package (afu_pkg) holds:
  - CL_DATA_WIDTH and WORD_WIDTH constants.
  - WORDS_PER_CL.
  - count_t (SIZE_WIDTH count type).
  - State enum t_unpack_state.
- Single module. The FSM plus datapath stays around 150–250 lines, so no sub-module.

Test Plan:
- Single line, num_lines=1, line words = 0x0..0xF, out_ready=1:
  - 16 beats of 0..15 on consecutive cycles.
  - out_last only on value 0xF.
  - done=1 the cycle after, with exactly one pop.
- num_lines=4, FIFO pre-filled, out_ready=1:
  - 64 beats in 64 consecutive cycles with no bubble.
  - dma_rd_en pulses 4 times.
  - done after beat 64.
- Backpressure, num_lines=1, out_ready toggling 1,0,0,1…:
  - out_data holds during stalls.
  - Sequence stays 0..15 with no duplicates or drops.
- num_lines=2 with FIFO empty for 10 cycles between lines:
  - dma_rd_en never asserted while dma_empty.
  - out_valid=0 during the gap.
  - 32 correct words, then done.
- num_lines=0:
  - No pops, no beats.
  - done=1 one cycle after go.
  - A second go with num_lines=1 clears done and completes normally.
- Reset and ignored go:
  - rst_n low after beat 5 forces out_valid=0 and done=0 immediately.
  - go during DRAIN leaves lines_rem unchanged and causes no extra pop.

Source files
------------

// File: rtl/afu_pkg.sv
// Shared AFU constants and types for the cache-line read path.
package afu_pkg;

  localparam int CL_DATA_WIDTH = 512;
  localparam int WORD_WIDTH    = 32;
  localparam int SIZE_WIDTH    = 65;
  localparam int WORDS_PER_CL  = CL_DATA_WIDTH / WORD_WIDTH;

  typedef logic [SIZE_WIDTH-1:0] count_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } t_unpack_state;

endpackage

// File: rtl/dma_line_unpacker.sv
// Pops cache lines from a show-ahead DMA read FIFO and streams them out as
// WORD_WIDTH words, low word first, counting lines against a programmed size.
module dma_line_unpacker
  import afu_pkg::*;
#(
  parameter int CL_DATA_WIDTH = afu_pkg::CL_DATA_WIDTH,
  parameter int WORD_WIDTH    = afu_pkg::WORD_WIDTH,
  parameter int SIZE_WIDTH    = afu_pkg::SIZE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic [SIZE_WIDTH-1:0]    num_lines,
  input  logic                     dma_empty,
  input  logic [CL_DATA_WIDTH-1:0] dma_rd_data,
  output logic                     dma_rd_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     done,
  output t_unpack_state            o_dbg_state
);

  localparam int WPL   = CL_DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W = $clog2(WPL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPL - 1);

  // Handshake: a word moves on any cycle where out_valid && out_ready. Once
  // out_valid rises, out_data/out_last hold until that beat happens.

  t_unpack_state            r_state;
  t_unpack_state            w_next_state;
  logic [CL_DATA_WIDTH-1:0] r_line;
  logic [IDX_W-1:0]         r_word_idx;
  logic [SIZE_WIDTH-1:0]    r_lines_rem;

  logic w_beat;
  logic w_last_word;
  logic w_lines_zero;
  logic w_pop;
  logic w_start;

  assign w_beat       = (r_state == ST_DRAIN) && out_ready;
  assign w_last_word  = (r_word_idx == LAST_IDX);
  assign w_lines_zero = (r_lines_rem == '0);

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          w_start      = 1'b1;
          w_next_state = (num_lines == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!dma_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Reloading on the last-word beat keeps the stream gap-free.
        if (w_beat && w_last_word) begin
          if (w_lines_zero) begin
            w_next_state = ST_DONE;
          end else if (!dma_empty) begin
            w_pop = 1'b1;
          end else begin
            w_next_state = ST_FETCH;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_line      <= '0;
      r_word_idx  <= '0;
      r_lines_rem <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_start) begin
        r_lines_rem <= num_lines;
      end else if (w_pop) begin
        r_lines_rem <= r_lines_rem - SIZE_WIDTH'(1);
      end

      if (w_pop) begin
        r_line     <= dma_rd_data;
        r_word_idx <= '0;
      end else if (w_beat) begin
        r_line     <= r_line >> WORD_WIDTH;
        r_word_idx <= r_word_idx + IDX_W'(1);
      end
    end
  end

  assign dma_rd_en   = w_pop;
  assign out_valid   = (r_state == ST_DRAIN);
  assign out_data    = r_line[WORD_WIDTH-1:0];
  assign out_last    = (r_state == ST_DRAIN) && w_last_word && w_lines_zero;
  assign done        = (r_state == ST_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dma_line_unpacker.sv
// Directed bench for dma_line_unpacker: queue-backed DMA FIFO model, beat log
// and per-scenario tasks with hand-computed expected word streams.
module tb_dma_line_unpacker;
  import afu_pkg::*;

  localparam int CLW = 512;
  localparam int WW  = 32;
  localparam int SW  = 65;
  localparam int WPL = 16;

  logic           clk;
  logic           rst_n;
  logic           go;
  logic [SW-1:0]  num_lines;
  logic           dma_empty;
  logic [CLW-1:0] dma_rd_data;
  logic           dma_rd_en;
  logic           out_valid;
  logic           out_ready;
  logic [WW-1:0]  out_data;
  logic           out_last;
  logic           done;
  t_unpack_state  dbg_state;

  dma_line_unpacker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .num_lines   (num_lines),
    .dma_empty   (dma_empty),
    .dma_rd_data (dma_rd_data),
    .dma_rd_en   (dma_rd_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  logic [CLW-1:0] fifo_q[$];
  logic [WW-1:0]  got_q[$];
  logic           last_q[$];
  int             beat_cyc_q[$];
  logic [WW-1:0]  exp_q[$];

  int checks, errors;
  int cyc, pops, beats, rd_en_empty, stall_checks, done_cyc, go_cyc;
  bit prev_stall, prev_done;
  logic [WW-1:0] prev_data;
  logic          prev_last;

  // ---------------- driver tasks ----------------
  task automatic fifo_refresh();
    dma_empty   = (fifo_q.size() == 0);
    dma_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  function automatic logic [CLW-1:0] make_line(input logic [WW-1:0] base);
    logic [CLW-1:0] l;
    l = '0;
    for (int k = 0; k < WPL; k++) l[k*WW +: WW] = base + WW'(k);
    return l;
  endfunction

  // One clock: sample at negedge, advance, then update FIFO 1ns after posedge.
  task automatic tick();
    bit pop_now;
    @(negedge clk);
    cyc++;
    if (dma_rd_en && dma_empty) rd_en_empty++;
    pop_now = dma_rd_en && !dma_empty;
    if (pop_now) pops++;
    if (prev_stall) begin
      checks++;
      stall_checks++;
      if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 cyc, out_valid, out_data, out_last, prev_data, prev_last);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      last_q.push_back(out_last);
      beat_cyc_q.push_back(cyc);
      beats++;
    end
    if (done && !prev_done && done_cyc < 0) done_cyc = cyc;
    prev_done = done;
    @(posedge clk);
    #1;
    if (pop_now) void'(fifo_q.pop_front());
    go = 1'b0;
    fifo_refresh();
  endtask

  task automatic clear_logs();
    got_q.delete();
    last_q.delete();
    beat_cyc_q.delete();
    exp_q.delete();
    pops = 0;
    beats = 0;
    rd_en_empty = 0;
    stall_checks = 0;
    done_cyc = -1;
    prev_stall = 1'b0;
  endtask

  task automatic start(input logic [SW-1:0] n);
    num_lines = n;
    go = 1'b1;
    tick();
    go_cyc = cyc;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (done_cyc < 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: done not seen within %0d cycles, required done=1", budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; num_lines = '0; out_ready = 1'b1;
    fifo_q.delete();
    fifo_refresh();
    clear_logs();
    prev_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || done !== 1'b0 ||
        dma_rd_en !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_values: valid=%b data=%h last=%b done=%b rd_en=%b state=%0d, required all 0 / IDLE",
               out_valid, out_data, out_last, done, dma_rd_en, dbg_state);
    end
    tick();
    checks++;
    if (pops !== 0 || beats !== 0) begin
      errors++;
      $display("FAIL reset_idle: pops=%0d beats=%0d, required 0 0", pops, beats);
    end
  endtask

  task automatic test_zero_lines();
    clear_logs();
    start('0);
    repeat (4) tick();
    checks++;
    if (done_cyc !== go_cyc + 1) begin
      errors++;
      $display("FAIL zero_done_latency: done at cyc %0d, required %0d", done_cyc, go_cyc + 1);
    end
    checks++;
    if (pops !== 0 || beats !== 0) begin
      errors++;
      $display("FAIL zero_no_traffic: pops=%0d beats=%0d, required 0 0", pops, beats);
    end
    // A fresh go from DONE must clear done and run one line normally.
    fifo_q.push_back(make_line(32'h40));
    fifo_refresh();
    clear_logs();
    start(SW'(1));
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_rego_clear: done=%b, required 0", done);
    end
    run_to_done(60);
    checks++;
    if (got_q.size() != WPL) begin
      errors++;
      $display("FAIL zero_rego_count: beats=%0d, required %0d", got_q.size(), WPL);
    end else begin
      for (int i = 0; i < WPL; i++) begin
        checks++;
        if (got_q[i] !== 32'h40 + WW'(i)) begin
          errors++;
          $display("FAIL zero_rego_word%0d: got %h, required %h", i, got_q[i], 32'h40 + WW'(i));
        end
      end
    end
  endtask

  task automatic test_single_line();
    clear_logs();
    fifo_q.push_back(make_line(32'h0));
    fifo_refresh();
    start(SW'(1));
    run_to_done(60);
    for (int i = 0; i < WPL; i++) exp_q.push_back(WW'(i));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count: beats=%0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < WPL; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || last_q[i] !== (i == WPL - 1)) begin
          errors++;
          $display("FAIL single_word%0d: data=%h last=%b, required data=%h last=%b",
                   i, got_q[i], last_q[i], exp_q[i], (i == WPL - 1));
        end
      end
      checks++;
      if (beat_cyc_q[0] != go_cyc + 2 || beat_cyc_q[WPL-1] - beat_cyc_q[0] != WPL - 1) begin
        errors++;
        $display("FAIL single_timing: first=%0d span=%0d, required first=%0d span=%0d",
                 beat_cyc_q[0], beat_cyc_q[WPL-1] - beat_cyc_q[0], go_cyc + 2, WPL - 1);
      end
      checks++;
      if (done_cyc != beat_cyc_q[WPL-1] + 1) begin
        errors++;
        $display("FAIL single_done_cycle: done at %0d, required %0d", done_cyc, beat_cyc_q[WPL-1] + 1);
      end
    end
    checks++;
    if (pops !== 1) begin
      errors++;
      $display("FAIL single_pops: pops=%0d, required 1", pops);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int l = 0; l < 4; l++) fifo_q.push_back(make_line(WW'((l + 1) * 256)));
    fifo_refresh();
    start(SW'(4));
    run_to_done(150);
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < WPL; k++) exp_q.push_back(WW'((l + 1) * 256 + k));
    checks++;
    if (got_q.size() != 64) begin
      errors++;
      $display("FAIL b2b_count: beats=%0d, required 64", got_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 63)) begin
          errors++;
          $display("FAIL b2b_word%0d: data=%h last=%b, required data=%h last=%b",
                   i, got_q[i], last_q[i], exp_q[i], (i == 63));
        end
      end
      checks++;
      if (beat_cyc_q[63] - beat_cyc_q[0] != 63) begin
        errors++;
        $display("FAIL b2b_no_bubble: span=%0d, required 63", beat_cyc_q[63] - beat_cyc_q[0]);
      end
      checks++;
      if (done_cyc != beat_cyc_q[63] + 1) begin
        errors++;
        $display("FAIL b2b_done_cycle: done at %0d, required %0d", done_cyc, beat_cyc_q[63] + 1);
      end
    end
    checks++;
    if (pops !== 4) begin
      errors++;
      $display("FAIL b2b_pops: pops=%0d, required 4", pops);
    end
  endtask

  task automatic test_backpressure();
    int i;
    clear_logs();
    fifo_q.push_back(make_line(32'h500));
    fifo_refresh();
    start(SW'(1));
    i = 0;
    while (done_cyc < 0 && i < 200) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
      i++;
    end
    out_ready = 1'b1;
    checks++;
    if (done_cyc < 0 || stall_checks == 0) begin
      errors++;
      $display("FAIL bp_progress: done_cyc=%0d stalls=%0d, required done and stalls>0", done_cyc, stall_checks);
    end
    checks++;
    if (got_q.size() != WPL) begin
      errors++;
      $display("FAIL bp_count: beats=%0d, required %0d", got_q.size(), WPL);
    end else begin
      for (int k = 0; k < WPL; k++) begin
        checks++;
        if (got_q[k] !== 32'h500 + WW'(k)) begin
          errors++;
          $display("FAIL bp_word%0d: got %h, required %h", k, got_q[k], 32'h500 + WW'(k));
        end
      end
    end
  endtask

  task automatic test_fifo_gap();
    int n, gap_valid;
    clear_logs();
    fifo_q.push_back(make_line(32'h600));
    fifo_refresh();
    start(SW'(2));
    n = 0;
    while (beats < WPL && n < 100) begin
      tick();
      n++;
    end
    gap_valid = 0;
    for (int g = 0; g < 10; g++) begin
      tick();
      if (out_valid) gap_valid++;
    end
    fifo_q.push_back(make_line(32'h700));
    fifo_refresh();
    run_to_done(60);
    checks++;
    if (gap_valid !== 0) begin
      errors++;
      $display("FAIL gap_valid: valid cycles in gap=%0d, required 0", gap_valid);
    end
    checks++;
    if (rd_en_empty !== 0 || pops !== 2) begin
      errors++;
      $display("FAIL gap_pops: rd_en_while_empty=%0d pops=%0d, required 0 2", rd_en_empty, pops);
    end
    checks++;
    if (got_q.size() != 2 * WPL) begin
      errors++;
      $display("FAIL gap_count: beats=%0d, required %0d", got_q.size(), 2 * WPL);
    end else begin
      for (int i = 0; i < 2 * WPL; i++) begin
        checks++;
        if (got_q[i] !== ((i < WPL) ? 32'h600 + WW'(i) : 32'h700 + WW'(i - WPL))) begin
          errors++;
          $display("FAIL gap_word%0d: got %h, required %h", i, got_q[i],
                   (i < WPL) ? 32'h600 + WW'(i) : 32'h700 + WW'(i - WPL));
        end
      end
    end
  endtask

  task automatic test_ignored_go();
    int n;
    clear_logs();
    fifo_q.push_back(make_line(32'h800));
    fifo_q.push_back(make_line(32'h900));
    fifo_refresh();
    start(SW'(1));
    n = 0;
    while (beats < 3 && n < 50) begin
      tick();
      n++;
    end
    num_lines = SW'(5);
    go = 1'b1;
    tick();
    run_to_done(60);
    checks++;
    if (beats !== WPL || pops !== 1 || fifo_q.size() != 1) begin
      errors++;
      $display("FAIL ignored_go: beats=%0d pops=%0d fifo_left=%0d, required %0d 1 1",
               beats, pops, fifo_q.size(), WPL);
    end
    fifo_q.delete();
    fifo_refresh();
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    fifo_q.push_back(make_line(32'hA00));
    fifo_q.push_back(make_line(32'hB00));
    fifo_refresh();
    start(SW'(2));
    n = 0;
    while (beats < 5 && n < 50) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || dma_rd_en !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_async: valid=%b done=%b rd_en=%b state=%0d, required 0 0 0 IDLE",
               out_valid, done, dma_rd_en, dbg_state);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (beats !== 5 || pops !== 1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: beats=%0d pops=%0d valid=%b, required 5 1 0", beats, pops, out_valid);
    end
    fifo_q.delete();
    fifo_refresh();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    go_cyc = 0;
    test_reset();
    test_zero_lines();
    test_single_line();
    test_back_to_back();
    test_backpressure();
    test_fifo_gap();
    test_ignored_go();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
